// File: rtl/cpu4_pkg.sv
// Shared encodings for the 4-bit CPU register-file sequencer.
// Opcodes, ALU ops, write-data select codes and FSM states.
package cpu4_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MDR = 2'b01;
  localparam logic [1:0] WSEL_RB  = 2'b10;

  localparam logic [1:0] REG_IN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_MOV,
    C_LD,
    C_IN,
    C_HALT,
    C_ILL
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [1:0] alu_op;
    logic [1:0] wsel;
    logic       r2_viol;
  } dec_t;

endpackage

// File: rtl/rf_seq_decode.sv
// Combinational instruction classifier for rf_seq_ctrl.
// R2 is only writable through the input port.
module rf_seq_decode
  import cpu4_pkg::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  logic [1:0] rd;
  assign rd = ir[3:2];

  // classify opcode, pick ALU op and write source, flag R2 writes
  always_comb begin
    dec.cls     = C_ILL;
    dec.alu_op  = ALU_ADD;
    dec.wsel    = WSEL_ALU;
    dec.r2_viol = 1'b0;
    case (ir[7:4])
      OP_NOP:  dec.cls = C_NOP;
      OP_ADD: begin
        dec.cls    = C_ALU;
        dec.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        dec.cls    = C_ALU;
        dec.alu_op = ALU_SUB;
      end
      OP_AND: begin
        dec.cls    = C_ALU;
        dec.alu_op = ALU_AND;
      end
      OP_OR: begin
        dec.cls    = C_ALU;
        dec.alu_op = ALU_OR;
      end
      OP_MOV: begin
        dec.cls  = C_MOV;
        dec.wsel = WSEL_RB;
      end
      OP_LD: begin
        dec.cls  = C_LD;
        dec.wsel = WSEL_MDR;
      end
      OP_IN:   dec.cls = C_IN;
      OP_HALT: dec.cls = C_HALT;
      default: dec.cls = C_ILL;
    endcase
    if ((dec.cls == C_ALU || dec.cls == C_MOV ||
         dec.cls == C_LD) && rd == REG_IN)
      dec.r2_viol = 1'b1;
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Multi-cycle sequencer driving the 4x4-bit register file,
// ALU op, write-data mux, input port and indirect memory reads.
module rf_seq_ctrl
  import cpu4_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] rf_a,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic       rf_re,
  output logic [1:0] rf_wr,
  output logic [1:0] wsel,
  output logic [3:0] mdr,
  output logic [1:0] alu_op,
  output logic       in_e,
  output logic [3:0] mem_addr,
  output logic       mem_rd,
  input  logic [3:0] mem_rdata,
  input  logic       mem_ack,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] retired
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] ir_q;
  logic [3:0] mdr_q;
  logic [7:0] timer_q;
  logic [7:0] retired_q;
  logic [3:0] mem_addr_q;
  logic [1:0] rf_ra_q;
  logic [1:0] rf_rb_q;
  logic [1:0] rf_wr_q;
  logic [1:0] wsel_q;
  logic [1:0] alu_op_q;
  logic       rf_re_q;
  logic       in_e_q;
  logic       mem_rd_q;
  logic       illegal_q;

  dec_t       dec;
  logic [1:0] rd;
  logic [1:0] rs;

  assign rd = ir_q[3:2];
  assign rs = ir_q[1:0];

  rf_seq_decode u_dec (
    .ir  (ir_q),
    .dec (dec)
  );

  // sequencer: state, IR/MDR, timer, retire count, registered strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      mdr_q      <= '0;
      timer_q    <= '0;
      retired_q  <= '0;
      mem_addr_q <= '0;
      rf_ra_q    <= '0;
      rf_rb_q    <= '0;
      rf_wr_q    <= '0;
      wsel_q     <= '0;
      alu_op_q   <= '0;
      rf_re_q    <= 1'b0;
      in_e_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rf_re_q   <= 1'b0;
      in_e_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q <= S_IDLE;
          if (dec.r2_viol) begin
            illegal_q <= 1'b1;
          end else begin
            case (dec.cls)
              C_ALU, C_MOV: begin
                state_q  <= S_EXEC;
                rf_ra_q  <= rd;
                rf_rb_q  <= rs;
                rf_wr_q  <= rd;
                rf_re_q  <= 1'b1;
                alu_op_q <= dec.alu_op;
                wsel_q   <= dec.wsel;
              end
              C_IN: begin
                state_q <= S_EXEC;
                in_e_q  <= 1'b1;
              end
              C_LD: begin
                state_q  <= S_MEM_REQ;
                rf_ra_q  <= rs;
                mem_rd_q <= 1'b1;
              end
              C_NOP:   retired_q <= retired_q + 8'd1;
              C_HALT:  state_q <= S_HALT;
              default: illegal_q <= 1'b1;
            endcase
          end
        end
        S_EXEC: begin
          state_q   <= S_IDLE;
          retired_q <= retired_q + 8'd1;
        end
        S_MEM_REQ: begin
          mem_addr_q <= rf_a;
          mem_rd_q   <= 1'b1;
          timer_q    <= '0;
          state_q    <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            mdr_q   <= mem_rdata;
            state_q <= S_WB;
            rf_re_q <= 1'b1;
            rf_wr_q <= rd;
            wsel_q  <= WSEL_MDR;
          end else if (timer_q == TMO_LAST) begin
            illegal_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            timer_q  <= timer_q + 8'd1;
            mem_rd_q <= 1'b1;
          end
        end
        S_WB: begin
          state_q   <= S_IDLE;
          retired_q <= retired_q + 8'd1;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign halted      = (state_q == S_HALT);
  assign rf_ra       = rf_ra_q;
  assign rf_rb       = rf_rb_q;
  assign rf_re       = rf_re_q;
  assign rf_wr       = rf_wr_q;
  assign wsel        = wsel_q;
  assign mdr         = mdr_q;
  assign alu_op      = alu_op_q;
  assign in_e        = in_e_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl: register-file/memory environment,
// instruction-level reference model, vector table and random run.
module tb_rf_seq_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] rf_a;
  logic [1:0] rf_ra, rf_rb, rf_wr, wsel, alu_op;
  logic       rf_re, in_e, mem_rd, mem_ack;
  logic [3:0] mdr, mem_addr, mem_rdata;
  logic       busy, halted, illegal;
  logic [7:0] retired;

  always #5 clk = ~clk;

  rf_seq_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rf_a(rf_a), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_re(rf_re),
    .rf_wr(rf_wr), .wsel(wsel), .mdr(mdr), .alu_op(alu_op),
    .in_e(in_e), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  // environment: register file, input port, memory responder
  logic [3:0] rf [4];
  logic [3:0] mem [16];
  logic [3:0] ind = '0;
  int         ack_k = 99;
  logic       force_ack = 1'b0;
  int         wcnt;

  assign rf_a      = rf[rf_ra];
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = force_ack | (mem_rd && wcnt == ack_k + 1);

  function automatic logic [3:0] alu_f(input logic [1:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      2'b00:   return 4'(a + b);
      2'b01:   return 4'(a - b);
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      wcnt <= 0;
    end else begin
      if (rf_re) begin
        case (wsel)
          2'b00:   rf[rf_wr] <= alu_f(alu_op, rf[rf_ra], rf[rf_rb]);
          2'b01:   rf[rf_wr] <= mdr;
          default: rf[rf_wr] <= rf[rf_rb];
        endcase
      end
      if (in_e) rf[2] <= ind;
      wcnt <= mem_rd ? wcnt + 1 : 0;
    end
  end

  // event monitor
  int cyc = 0, n_wr = 0, n_ill = 0, n_mrd = 0, n_both = 0;
  int wr_cyc = -1;
  logic [1:0] l_wr = '0, l_alu = '0, l_wsel = '0, l_ra = '0, l_rb = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_re) begin
      n_wr   <= n_wr + 1;
      l_wr   <= rf_wr;
      l_alu  <= alu_op;
      l_wsel <= wsel;
      l_ra   <= rf_ra;
      l_rb   <= rf_rb;
    end
    if (rf_re || in_e) wr_cyc <= cyc;
    if (illegal) n_ill <= n_ill + 1;
    if (mem_rd) n_mrd <= n_mrd + 1;
    if (rf_re && in_e) n_both <= n_both + 1;
  end

  // checking
  int errs = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // instruction-level reference model
  logic [3:0] m_rf [4];
  int         m_ret = 0;

  task automatic model_exec(input logic [7:0] ins, input logic [3:0] iv,
                            input int k, output int lat, output bit ill,
                            output int woff, output int nwr,
                            output int mrd);
    logic [3:0] op;
    logic [1:0] rd, rs;
    op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0];
    lat = 2; ill = 0; woff = -1; nwr = 0; mrd = 0;
    if (op >= 4'd1 && op <= 4'd6 && rd == 2'd2) begin
      ill = 1;
    end else begin
      case (op)
        4'd0: m_ret++;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          case (op)
            4'd1:    m_rf[rd] = 4'(m_rf[rd] + m_rf[rs]);
            4'd2:    m_rf[rd] = 4'(m_rf[rd] - m_rf[rs]);
            4'd3:    m_rf[rd] = m_rf[rd] & m_rf[rs];
            4'd4:    m_rf[rd] = m_rf[rd] | m_rf[rs];
            default: m_rf[rd] = m_rf[rs];
          endcase
          lat = 3; woff = 2; nwr = 1; m_ret++;
        end
        4'd6: begin
          if (k < TMO) begin
            m_rf[rd] = mem[m_rf[rs]];
            lat = 5 + k; woff = 4 + k; nwr = 1; mrd = k + 2;
            m_ret++;
          end else begin
            lat = 3 + TMO; ill = 1; mrd = TMO + 1;
          end
        end
        4'd7: begin
          m_rf[2] = iv;
          lat = 3; woff = 2; m_ret++;
        end
        default: ill = 1;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_ret = 0;
  endtask

  int acc_cyc, s_wr, s_ill, s_mrd;

  task automatic issue(input logic [7:0] ins, input logic [3:0] iv,
                       input int k);
    int n = 0;
    while (!instr_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_issue", int'(instr_ready), 1);
    s_wr  = n_wr;
    s_ill = n_ill + int'(illegal);
    s_mrd = n_mrd;
    instr = ins; ind = iv; ack_k = k; instr_valid = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic complete(input string tag, input int lat, input bit ill,
                          input int woff, input int nwr, input int mrd);
    int n = 0;
    while (!instr_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, cyc - acc_cyc, lat);
    chk({tag, "_illegal"}, n_ill - s_ill + int'(illegal), int'(ill));
    chk({tag, "_rf_writes"}, n_wr - s_wr, nwr);
    chk({tag, "_mem_rd_cycles"}, n_mrd - s_mrd, mrd);
    if (woff >= 0) chk({tag, "_write_cycle"}, wr_cyc - acc_cyc, woff);
    chk({tag, "_rf"}, int'({rf[3], rf[2], rf[1], rf[0]}),
        int'({m_rf[3], m_rf[2], m_rf[1], m_rf[0]}));
    chk({tag, "_retired"}, int'(retired), m_ret % 256);
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [3:0] iv;
    int         k;
    int         lat;
    bit         ill;
  } vec_t;

  vec_t vq[$];

  initial begin
    int lat, woff, nwr, mrd, addr;
    bit ill;
    logic [3:0] op;

    for (int i = 0; i < 16; i++) mem[i] = 4'(i + 4);
    model_reset();

    // reset state
    #12;
    chk("rst_strobes", int'({rf_re, in_e, mem_rd, illegal}), 0);
    chk("rst_status", int'({busy, halted}), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_mdr_addr", int'({mdr, mem_addr}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", int'(instr_ready), 1);

    // ins, ind, ack wait, latency, illegal
    vq.push_back('{8'h70, 4'h3, 99, 3, 1'b0});
    vq.push_back('{8'h52, 4'h3, 99, 3, 1'b0});
    vq.push_back('{8'h70, 4'h5, 99, 3, 1'b0});
    vq.push_back('{8'h56, 4'h5, 99, 3, 1'b0});
    vq.push_back('{8'h14, 4'h5, 99, 3, 1'b0});
    vq.push_back('{8'h70, 4'h9, 99, 3, 1'b0});
    vq.push_back('{8'h5E, 4'h9, 99, 3, 1'b0});
    vq.push_back('{8'h70, 4'h6, 99, 3, 1'b0});
    vq.push_back('{8'h56, 4'h6, 99, 3, 1'b0});
    vq.push_back('{8'h6D, 4'h6, 2,  7, 1'b0});
    vq.push_back('{8'h00, 4'h6, 99, 2, 1'b0});
    vq.push_back('{8'h58, 4'h6, 99, 2, 1'b1});
    vq.push_back('{8'hC0, 4'h6, 99, 2, 1'b1});
    vq.push_back('{8'h69, 4'h6, 0,  2, 1'b1});
    vq.push_back('{8'h2D, 4'h6, 99, 3, 1'b0});
    vq.push_back('{8'h33, 4'h6, 99, 3, 1'b0});
    vq.push_back('{8'h41, 4'h6, 99, 3, 1'b0});
    vq.push_back('{8'h63, 4'h6, 99, 18, 1'b1});
    vq.push_back('{8'h60, 4'h6, 0,  5, 1'b0});
    vq.push_back('{8'h65, 4'h6, 14, 19, 1'b0});
    vq.push_back('{8'h64, 4'h6, 15, 18, 1'b1});
    vq.push_back('{8'h7C, 4'hF, 99, 3, 1'b0});
    vq.push_back('{8'h80, 4'hF, 99, 2, 1'b1});
    vq.push_back('{8'hE7, 4'hF, 99, 2, 1'b1});

    foreach (vq[i]) begin
      model_exec(vq[i].ins, vq[i].iv, vq[i].k, lat, ill, woff, nwr, mrd);
      issue(vq[i].ins, vq[i].iv, vq[i].k);
      complete($sformatf("vec%0d", i), vq[i].lat, vq[i].ill,
               woff, nwr, mrd);
    end

    // ADD R1 += R0: EXEC-cycle control fields
    model_exec(8'h14, 4'h0, 99, lat, ill, woff, nwr, mrd);
    issue(8'h14, 4'h0, 99);
    complete("add", 3, 1'b0, woff, nwr, mrd);
    chk("add_ctrl", int'({l_wr, l_alu, l_wsel, l_ra, l_rb}),
        int'({2'd1, 2'd0, 2'd0, 2'd1, 2'd0}));

    // LD R3 <= mem[R1]: address latched from R1, MDR captured
    addr = int'(m_rf[1]);
    model_exec(8'h6D, 4'h0, 2, lat, ill, woff, nwr, mrd);
    issue(8'h6D, 4'h0, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ld_wait_mem_rd", int'(mem_rd), 1);
    chk("ld_mem_addr", int'(mem_addr), addr);
    complete("ld", 7, 1'b0, woff, nwr, mrd);
    chk("ld_mdr", int'(mdr), int'(mem[addr]));

    // randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ins;
      logic [3:0] iv;
      int k;
      case ($urandom_range(0, 9))
        0: op = 4'h0; 1: op = 4'h1; 2: op = 4'h2; 3: op = 4'h3;
        4: op = 4'h4; 5: op = 4'h5; 6: op = 4'h6; 7: op = 4'h6;
        8: op = 4'h7;
        default: op = 4'(8 + $urandom_range(0, 6));
      endcase
      ins = {op, 4'($urandom_range(0, 15))};
      iv  = 4'($urandom_range(0, 15));
      k   = $urandom_range(0, 16);
      model_exec(ins, iv, k, lat, ill, woff, nwr, mrd);
      issue(ins, iv, k);
      complete($sformatf("rnd%0d_%02h", i, ins), lat, ill,
               woff, nwr, mrd);
    end

    // HALT: ready stays low, valid ignored, reset recovers
    issue(8'hF0, 4'h0, 99);
    @(posedge clk); #1;
    s_wr = n_wr;
    instr = 8'h14; instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("halt_ready_low", int'(instr_ready), 0);
      chk("halt_flag", int'(halted), 1);
    end
    chk("halt_no_write", n_wr - s_wr, 0);
    chk("halt_retired", int'(retired), m_ret % 256);
    reset = 1'b0;
    #1;
    chk("halt_rst_async", int'({halted, busy}), 0);
    chk("halt_rst_retired", int'(retired), 0);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("halt_rst_ready", int'(instr_ready), 1);

    // reset while waiting on memory
    issue(8'h6D, 4'h0, 99);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_ld_mem_rd", int'({busy, mem_rd}), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_ld_rst_mem_rd", int'(mem_rd), 0);
    chk("mid_ld_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    s_wr = n_wr;
    force_ack = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    force_ack = 1'b0;
    chk("post_rst_no_wb", n_wr - s_wr, 0);
    chk("post_rst_idle", int'({instr_ready, busy}), 2);
    chk("post_rst_retired", int'(retired), 0);
    chk("post_rst_mdr", int'(mdr), 0);

    chk("re_in_e_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
